// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, op encodings and state type for the iterative mul/div unit
package mdu_pkg;

  localparam int W    = 32;
  localparam int ITER = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX,
    ST_DONE,
    ST_HOLD
  } mdu_state_e;

  // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// rtl/mdu_shift_core.sv - 64-bit accumulator/remainder datapath doing one mul or div step per cycle
module mdu_shift_core
  import mdu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           is_div,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic [2*W-1:0] acc
);

  // Upper half is the running partial product / remainder, lower half shifts
  // out multiplier bits (mul) or dividend bits while quotient bits shift in (div).
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   opb_q, opb_d;

  logic [W-1:0]   addend;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic           rem_ge;
  logic [W-1:0]   rem_sub;

  // Single shift-add or restoring-subtract step, or a fresh operand load.
  always_comb begin
    acc_d   = acc_q;
    opb_d   = opb_q;
    addend  = acc_q[0] ? opb_q : '0;
    mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend};
    // Partial remainder shifted left with the next dividend bit appended.
    rem_sh  = acc_q[2*W-1:W-1];
    rem_ge  = (rem_sh >= {1'b0, opb_q});
    // When rem_ge holds the difference is below the divisor, so W bits suffice.
    rem_sub = rem_sh[W-1:0] - opb_q;
    if (load) begin
      acc_d = {{W{1'b0}}, a_in};
      opb_d = b_in;
    end else if (step) begin
      if (is_div) begin
        if (rem_ge) begin
          acc_d = {rem_sub, acc_q[W-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
        end
      end else begin
        acc_d = {mul_sum, acc_q[W-1:1]};
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      opb_q <= '0;
    end else begin
      acc_q <= acc_d;
      opb_q <= opb_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mdu_iter_unit.sv
// rtl/mdu_iter_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO with hazard stall/done handshake
module mdu_iter_unit
  import mdu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         flush,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] mt_wdata,
  output logic         alu_stall,
  output logic         alu_done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  mdu_state_e     state_q, state_d;
  logic [4:0]     count_q, count_d;
  logic           is_div_q, is_div_d;
  logic           q_neg_q, q_neg_d;
  logic           r_neg_q, r_neg_d;
  logic [2*W-1:0] res_q, res_d;
  logic [W-1:0]   hi_q, hi_d;
  logic [W-1:0]   lo_q, lo_d;

  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic           core_load;
  logic           core_step;
  logic [2*W-1:0] core_acc;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[W-1];
  assign b_neg     = signed_op & b[W-1];
  assign core_load = (state_q == ST_IDLE) && start && !flush;
  assign core_step = (state_q == ST_CALC);

  mdu_shift_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
    .is_div (is_div_q),
    .a_in   (cond_neg(a, a_neg)),
    .b_in   (cond_neg(b, b_neg)),
    .acc    (core_acc)
  );

  // Next-state, sign fix-up and HI/LO update; the DONE commit overrides MT writes.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    is_div_d = is_div_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    res_d    = res_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (hi_we) hi_d = mt_wdata;
    if (lo_we) lo_d = mt_wdata;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_CALC;
          count_d  = 5'd0;
          is_div_d = op[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
        end
      end
      ST_CALC: begin
        if (count_q == 5'(ITER - 1)) begin
          state_d = ST_FIX;
        end else begin
          count_d = count_q + 5'd1;
        end
      end
      ST_FIX: begin
        if (is_div_q) begin
          res_d = {cond_neg(core_acc[2*W-1:W], r_neg_q), cond_neg(core_acc[W-1:0], q_neg_q)};
        end else begin
          res_d = q_neg_q ? (~core_acc + 64'd1) : core_acc;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!flush) begin
          hi_d = res_q[2*W-1:W];
          lo_d = res_q[W-1:0];
        end
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // Wait for the completed instruction to leave EX before re-arming.
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Control and architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      is_div_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      res_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      is_div_q <= is_div_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      res_q    <= res_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Stall is combinational so the pipeline freezes in the arrival cycle.
  assign alu_stall = !flush && (((state_q == ST_IDLE) && start) ||
                                (state_q == ST_CALC) ||
                                (state_q == ST_FIX)  ||
                                (state_q == ST_DONE));
  assign alu_done  = !flush && (state_q == ST_DONE);
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_iter_unit.sv
// tb/tb_mdu_iter_unit.sv - self-checking bench for mdu_iter_unit
module tb_mdu_iter_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] mt_wdata = '0;
  logic        alu_stall;
  logic        alu_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mdu_iter_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .mt_wdata  (mt_wdata),
    .alu_stall (alu_stall),
    .alu_done  (alu_done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result from plain arithmetic: {HI, LO}.
  function automatic logic [63:0] golden(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MDU_MULT:  res = sx * sy;
      MDU_MULTU: res = {32'b0, x} * {32'b0, y};
      MDU_DIV: begin
        if (sy == 0) begin
          q = (sx < 0) ? 64'sd1 : -64'sd1;
          r = sx;
        end else begin
          q = sx / sy;
          r = sx % sy;
        end
        res = {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) res = {x, 32'hFFFF_FFFF};
        else        res = {x % y, x / y};
      end
    endcase
    return res;
  endfunction

  // Cycle model: idle, busy for cycles 1..34 (34 = completion), then hold.
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_HOLD = 2;
  int          m_st = M_IDLE;
  int          m_cnt = 0;
  logic [63:0] m_res = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_st    = M_IDLE;
      m_cnt   = 0;
      m_hi    = '0;
      m_lo    = '0;
      m_valid = 1'b1;
    end else begin
      if (hi_we) m_hi = mt_wdata;
      if (lo_we) m_lo = mt_wdata;
      if (flush) begin
        m_st = M_IDLE;
      end else if (m_st == M_IDLE) begin
        if (start) begin
          m_st  = M_BUSY;
          m_cnt = 1;
          m_res = golden(op, a, b);
        end
      end else if (m_st == M_BUSY) begin
        if (m_cnt == 34) begin
          m_hi = m_res[63:32];
          m_lo = m_res[31:0];
          m_st = M_HOLD;
        end else begin
          m_cnt++;
        end
      end else begin
        if (!start) m_st = M_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("model_stall", {31'b0, alu_stall},
          {31'b0, !flush && ((m_st == M_IDLE && start) || m_st == M_BUSY)});
      chk("model_done", {31'b0, alu_done},
          {31'b0, !flush && m_st == M_BUSY && m_cnt == 34});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int extra, input bit mt_done, output int nstall, output int dcyc);
    bit seen;
    seen   = 1'b0;
    nstall = 0;
    dcyc   = -1;
    op     = o;
    a      = x;
    b      = y;
    start  = 1'b1;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge clk);
      if (alu_stall) nstall++;
      if (alu_done) begin
        seen = 1'b1;
        dcyc = c;
        if (mt_done) begin
          lo_we    = 1'b1;
          mt_wdata = 32'h0000_1234;
        end
      end
      tick();
      lo_we = 1'b0;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL op_timeout: got no alu_done expected alu_done within 60 cycles");
    end
    for (int c = 0; c < extra; c++) begin
      @(negedge clk);
      if (alu_stall) nstall++;
      tick();
    end
    start = 1'b0;
    tick();
  endtask

  task automatic check_hl(input string nm, input logic [31:0] eh, input logic [31:0] el);
    @(negedge clk);
    chk({nm, "_hi"}, hi, eh);
    chk({nm, "_lo"}, lo, el);
    tick();
  endtask

  initial begin
    int ns;
    int dc;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_stall", {31'b0, alu_stall}, 32'h0);
    chk("reset_done", {31'b0, alu_done}, 32'h0);
    tick();

    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd7, 0, 1'b0, ns, dc);
    chk("mult_stall_cycles", ns, 32'd35);
    chk("mult_done_cycle", dc, 32'd34);
    check_hl("mult_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    run_op(MDU_DIVU, 32'd100, 32'd7, 0, 1'b0, ns, dc);
    check_hl("divu_100_7", 32'd2, 32'd14);

    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, ns, dc);
    check_hl("div_m7_2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op(MDU_DIVU, 32'd5, 32'd0, 0, 1'b0, ns, dc);
    check_hl("divu_by0", 32'd5, 32'hFFFF_FFFF);

    run_op(MDU_DIV, 32'hFFFF_FFF8, 32'd0, 0, 1'b0, ns, dc);
    check_hl("div_m8_by0", 32'hFFFF_FFF8, 32'h0000_0001);

    run_op(MDU_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1'b0, ns, dc);
    check_hl("mult_minneg", 32'h4000_0000, 32'h0000_0000);

    op    = MDU_DIV;
    a     = 32'hFFFF_FF9C;
    b     = 32'd3;
    start = 1'b1;
    repeat (10) tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, alu_stall}, 32'h0);
    chk("flush_done", {31'b0, alu_done}, 32'h0);
    tick();
    flush = 1'b0;
    start = 1'b0;
    check_hl("flush_keep", 32'h4000_0000, 32'h0000_0000);

    run_op(MDU_MULT, 32'd1234, 32'hFFFF_FFFF, 0, 1'b0, ns, dc);
    chk("post_flush_stall_cycles", ns, 32'd35);
    check_hl("mult_after_flush", 32'hFFFF_FFFF, 32'hFFFF_FB2E);

    hi_we    = 1'b1;
    mt_wdata = 32'h0000_0055;
    tick();
    hi_we = 1'b0;
    check_hl("mthi_idle", 32'h0000_0055, 32'hFFFF_FB2E);

    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b1, ns, dc);
    chk("hold_stall_cycles", ns, 32'd35);
    check_hl("multu_max_mtlo", 32'hFFFF_FFFE, 32'h0000_0001);

    op    = MDU_DIVU;
    a     = 32'd9;
    b     = 32'd2;
    start = 1'b1;
    repeat (5) tick();
    rst   = 1'b1;
    start = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_stall", {31'b0, alu_stall}, 32'h0);
    chk("midrst_done", {31'b0, alu_done}, 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    tick();

    run_op(MDU_DIVU, 32'd9, 32'd2, 0, 1'b0, ns, dc);
    check_hl("divu_after_rst", 32'd1, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mdu_iter_unit.md
# mdu_iter_unit

Iterative multiply/divide unit in the EX stage, directly upstream of the hazard detection control. It executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle schedule and owns the HI/LO registers. It drives the `alu_stall`/`alu_done` pair that the hazard controller uses to freeze F/D/E/M/W and then insert its two post-mul/div stall cycles.

## Interface
- `W`, 32, operand/HI/LO width
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  level; EX holds a mul/div instruction (held stable by StallE while stalled)
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled when leaving IDLE
- `a`, `b`  in  W  rs / rt operand values (forwarded); sampled when leaving IDLE
- `flush`  in  1  exception clean of EX; aborts any operation
- `hi_we`, `lo_we`  in  1  MTHI / MTLO write enables
- `mt_wdata`  in  W  MTHI/MTLO data
- `alu_stall`  out  1  mul/div in progress for the current EX instruction
- `alu_done`  out  1  one-cycle completion pulse
- `hi`, `lo`  out  W  architectural HI/LO

## Operation
- States: IDLE, CALC, FIX, DONE, HOLD.
- IDLE: if `start && !flush`, latch `op`, |a|, |b| (magnitudes for signed ops, raw for unsigned), sign flags, count=0 -> CALC.
- CALC: one shift-add step (multiply) or one restoring subtract step (divide) per cycle; count 0..31; after count==31 -> FIX.
- FIX: signed mul: negate 64-bit product if signs differ. Signed div: negate quotient if signs differ; remainder takes sign of dividend. -> DONE.
- DONE: commit {HI,LO} = product[63:32]/[31:0], or HI = remainder, LO = quotient; `alu_done`=1 -> HOLD.
- HOLD: ignore `start`; return to IDLE on the first cycle `start`=0. Prevents a restart on the still-held instruction. Back-to-back mul/div always sees a bubble because the hazard controller flushes EX after completion.
- `alu_stall` = !flush && ((IDLE && start) || CALC || FIX || DONE). Combinational, so the hazard controller stalls in the same cycle the instruction arrives.
- Divide by zero: quotient = all ones (signed: then sign-fixed), remainder = dividend. No trap.
- Most negative operand: magnitude 2^31 fits in W unsigned bits; no special case.
- `flush` in any state: next state IDLE, no HI/LO commit; `alu_stall` and `alu_done` forced 0 that cycle.
- `hi_we`/`lo_we` write HI/LO in any state. The DONE commit takes priority over a same-cycle MT write, because the MT instruction is older in program order.
- `rst`: state IDLE, count 0, HI=LO=0, `alu_stall`=`alu_done`=0.

## Timing
- Cycle 0: start seen in IDLE, `alu_stall`=1.
- Cycles 1-32: CALC.
- Cycle 33: FIX.
- Cycle 34: DONE, `alu_done`=1, HI/LO visible from cycle 35.
- Total: 35 cycles of `alu_stall`=1, of which cycle 34 also has `alu_done`=1.
- A reset or flush mid-operation takes effect at the next edge. A new operation is possible 1 cycle after `start` drops.
- HI/LO update only at the DONE edge or on MT writes; they never glitch mid-operation.

## Structure
- Package `mdu_pkg`: `W`, op encodings (`MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`), state enum, `ITER = 32`.
- Sub-module `mdu_shift_core`: 64-bit accumulator/remainder + 32-bit shift register and a single-step mul/div datapath, controlled by `load`/`step`/`is_div`. The FSM, sign handling and HI/LO stay in the top module.

## Test plan
- MULT a=-3, b=7: `alu_stall` high cycles 0-34, `alu_done` at cycle 34 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU a=100, b=7 -> LO=14, HI=2. DIV a=-7, b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIVU a=5, b=0 -> LO=0xFFFFFFFF, HI=5. MULTU 0xFFFFFFFF² -> HI=0xFFFFFFFE, LO=0x00000001.
- `flush` at cycle 10 of DIV: unit returns to IDLE and HI/LO keep their old values. A new MULT started 1 cycle later completes with correct results.
- `start` held 3 extra cycles after `alu_done`: no restart, `alu_stall`=0 in HOLD. MTLO 0x1234 in the DONE cycle is overridden by the commit. MTHI 0x55 while IDLE -> HI=0x55 next cycle.
- `rst` asserted mid-CALC: next cycle all outputs are 0 and state is IDLE.
